d_mem_bridge8: RTL
==================

Name: d_mem_bridge8

Overview:
- Sits directly downstream of the core's data-memory port (d_mem_*).
- Converts each 16-bit core access, with its byte enables, into one or two beats on an 8-bit external memory bus that uses a req/ack handshake.
- Returns read data to the core and pulses d_mem_rdy when the access is complete.
- A per-beat timeout aborts a stalled beat; a transfer counter supports performance benches.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles a beat may wait for mem_ack before abort; 0 disables the timeout.
- CNT_W, 16: width of the perf_xfers counter.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- d_mem_assert  in  1  core access request; held with addr/cmd/be/data until d_mem_rdy
- d_mem_cmd  in  1  0=read, 1=write
- d_mem_addr  in  16  byte address
- d_mem_be0  in  1  byte enable, high byte
- d_mem_be1  in  1  byte enable, low byte
- d_mem_data_out  in  16  write data from core
- d_mem_data_in  out  16  read data to core; valid while d_mem_rdy=1
- d_mem_rdy  out  1  one-cycle completion pulse
- d_mem_err  out  1  high together with d_mem_rdy when the access was aborted by timeout
- mem_req  out  1  external beat request
- mem_we  out  1  beat is a write
- mem_addr  out  16  beat byte address
- mem_wdata  out  8  beat write byte
- mem_rdata  in  8  beat read byte; sampled on the edge where mem_ack=1
- mem_ack  in  1  beat complete; only meaningful while mem_req=1
- perf_xfers  out  CNT_W  count of completed core accesses; wraps

Behaviour:
- Reset (synchronous): state=IDLE. All outputs are 0 (data_in, rdy, err, mem_req, mem_we, mem_addr, mem_wdata, perf_xfers). An active mem beat is dropped at that edge, with no completion to the core.
- States: IDLE, BEAT0, BEAT1, DONE. All outputs are registered.
- IDLE:
  - If d_mem_assert=1 at the edge, latch cmd, addr, be and data.
  - be0&be1 (word access): BEAT0 with mem_addr={addr[15:1],0}; addr[0] is ignored.
  - Exactly one enable set (byte access): BEAT0 with mem_addr=addr.
  - Neither enable set: DONE directly with data_in=0 and no mem beat.
- BEAT0/BEAT1 write data:
  - Word access: even byte=data_out[15:8], odd byte=data_out[7:0].
  - Byte access: data_out[7:0].
- BEAT0/BEAT1 handshake:
  - mem_req=1. An edge with mem_ack=1 completes the beat.
  - Read beats capture mem_rdata into the assembly register.
- Word access: BEAT0 ack → BEAT1 with mem_addr={addr[15:1],1}. mem_req stays high, with no idle cycle between beats.
- After the last beat: DONE, mem_req=0.
- Read assembly:
  - Word: data_in={byte_even, byte_odd} (big-endian).
  - Byte: data_in={8'h00, byte}.
  - Writes: data_in=0.
- DONE:
  - d_mem_rdy=1 for exactly one cycle and perf_xfers increments.
  - Next state is always IDLE, so a request held across the rdy edge is not re-captured twice.
  - Throughput: one new capture per (beats+2) cycles.
- Latency with zero-wait ack, counted from the capture edge to the first rdy-high cycle:
  - Byte access: 2 cycles.
  - Word access: 3 cycles.
  - Each wait cycle on mem_ack adds 1.
- Timeout:
  - A wait counter resets at the start of each beat and increments every cycle with mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to DONE with err=1 and data_in=0, and skip any remaining beat. perf_xfers still increments.
  - An ack arriving on the same edge as the timeout wins; the beat completes normally.
- d_mem_assert deasserted mid-access: ignored; the access runs to completion.
- perf_xfers wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package d_mem_pkg:
  - State enum.
  - CMD_READ=1'b0, CMD_WRITE=1'b1.
  - Byte-lane helper constants (LANE_HI=15:8, LANE_LO=7:0).
- One sub-module, d_mem_beat_timer: the wait counter with start/ack/expire. It is reusable by the instruction-side bridge.

Test Plan:
- Word read, addr 16'hC001, memory C000=8'hC0 and C001=8'h11, zero-wait ack → mem_addr C000 then C001; data_in=16'hC011 on the 3rd cycle after capture; err=0.
- Byte write, addr 16'hB003, data_out=16'h12AB, be0=0, be1=1 → one beat: mem_we=1, mem_addr=B003, mem_wdata=8'hAB; rdy on the 2nd cycle.
- Word write with 2 wait cycles per beat, data_out=16'hBEEF at 16'h0010 → beats 0010=8'hBE, 0011=8'hEF; rdy on the 7th cycle; perf_xfers +1.
- mem_ack held low, TIMEOUT_CYCLES=15, word read → mem_req drops after 15 wait cycles; no second beat; rdy=1, err=1, data_in=16'h0000.
- rst asserted while in BEAT1 → next edge: mem_req=0, no rdy pulse, perf_xfers=0, state IDLE; a new request is accepted normally afterwards.
- 100 back-to-back byte reads with assert held high → exactly 100 rdy pulses; perf_xfers=100; no duplicate capture.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared types and constants for the data-side memory bridge and its helpers.
package d_mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2,
      S_DONE  = 2'd3
   } bridge_state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Byte-lane base offsets within a 16-bit word; use as [LANE_x +: 8].
   localparam int LANE_HI = 8;
   localparam int LANE_LO = 0;

endpackage

// File: rtl/d_mem_beat_timer.sv
// Per-beat wait counter: cleared on start, counts stalled cycles, flags expiry.
module d_mem_beat_timer #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   input  logic ack,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || start)
         cnt <= '0;
      else if (active && !ack && cnt != LAST)
         cnt <= cnt + 1'b1;
   end

   // Expires on the stalled edge that would make the wait count reach the limit.
   assign expire = (TIMEOUT_CYCLES != 0) && active && !ack && (cnt == LAST);

endmodule

// File: rtl/d_mem_bridge8.sv
// Splits 16-bit core data accesses into one or two req/ack beats on an 8-bit bus.
module d_mem_bridge8
   import d_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_mem_assert,
   input  logic             d_mem_cmd,
   input  logic [15:0]      d_mem_addr,
   input  logic             d_mem_be0,
   input  logic             d_mem_be1,
   input  logic [15:0]      d_mem_data_out,
   output logic [15:0]      d_mem_data_in,
   output logic             d_mem_rdy,
   output logic             d_mem_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [15:0]      mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] perf_xfers
);

   bridge_state_t state;
   logic          cmd_q;
   logic          word_q;
   logic [15:1]   addr_hi_q;
   logic [7:0]    wlo_q;
   logic [15:0]   asm_q;
   logic          to_q;
   logic          beat_start;
   logic          expire;
   logic          word_in;

   assign word_in    = d_mem_be0 & d_mem_be1;
   assign beat_start = ((state == S_IDLE) && d_mem_assert && (d_mem_be0 | d_mem_be1)) ||
                       ((state == S_BEAT0) && mem_ack && word_q);

   d_mem_beat_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (beat_start),
      .active (mem_req),
      .ack    (mem_ack),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cmd_q         <= CMD_READ;
         word_q        <= 1'b0;
         addr_hi_q     <= '0;
         wlo_q         <= '0;
         asm_q         <= '0;
         to_q          <= 1'b0;
         d_mem_data_in <= '0;
         d_mem_rdy     <= 1'b0;
         d_mem_err     <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         perf_xfers    <= '0;
      end else begin
         d_mem_rdy <= 1'b0;
         d_mem_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (d_mem_assert) begin
                  cmd_q     <= d_mem_cmd;
                  word_q    <= word_in;
                  addr_hi_q <= d_mem_addr[15:1];
                  wlo_q     <= d_mem_data_out[LANE_LO +: 8];
                  asm_q     <= '0;
                  to_q      <= 1'b0;
                  if (d_mem_be0 | d_mem_be1) begin
                     state     <= S_BEAT0;
                     mem_req   <= 1'b1;
                     mem_we    <= d_mem_cmd;
                     mem_addr  <= word_in ? {d_mem_addr[15:1], 1'b0} : d_mem_addr;
                     mem_wdata <= word_in ? d_mem_data_out[LANE_HI +: 8]
                                          : d_mem_data_out[LANE_LO +: 8];
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_BEAT0, S_BEAT1: begin
               // An ack on the expiry edge takes priority over the timeout.
               if (mem_ack) begin
                  if (cmd_q == CMD_READ) begin
                     if (!word_q)
                        asm_q <= {8'h00, mem_rdata};
                     else if (state == S_BEAT0)
                        asm_q <= {mem_rdata, 8'h00};
                     else
                        asm_q <= {asm_q[15:8], mem_rdata};
                  end
                  if (word_q && state == S_BEAT0) begin
                     state     <= S_BEAT1;
                     mem_addr  <= {addr_hi_q, 1'b1};
                     mem_wdata <= wlo_q;
                  end else begin
                     state   <= S_DONE;
                     mem_req <= 1'b0;
                     mem_we  <= 1'b0;
                  end
               end else if (expire) begin
                  state   <= S_DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  to_q    <= 1'b1;
               end
            end
            S_DONE: begin
               state         <= S_IDLE;
               d_mem_rdy     <= 1'b1;
               d_mem_err     <= to_q;
               d_mem_data_in <= (to_q || cmd_q == CMD_WRITE) ? 16'h0000 : asm_q;
               perf_xfers    <= perf_xfers + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
